sfr_ws2812_tx: RTL and testbench

//  SFR-mapped WS2812 full-colour LED frame transmitter on the DW8051 SFR bus.

---
 rtl/sfr_ws2812_tx_pkg.sv | 25 ++
 rtl/sfr_ws2812_tx_byte_fifo.sv | 71 +++++++
 rtl/sfr_ws2812_tx.sv | 175 +++++++++++++++++
 tb/tb_sfr_ws2812_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sfr_ws2812_tx_pkg.sv
// Shared definitions for the WS2812 SFR transmitter: default SFR addresses,
// WS_CTRL command bit positions, FSM state encodings and a status helper.
package sfr_ws2812_tx_pkg;

   localparam logic [7:0] DEF_DATA_ADDR = 8'hC1;
   localparam logic [7:0] DEF_CTRL_ADDR = 8'hC2;

   localparam int CTRL_START   = 0;
   localparam int CTRL_FLUSH   = 1;
   localparam int CTRL_CLR_OVF = 2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_HIGH  = 3'd2,
      S_LOW   = 3'd3,
      S_LATCH = 3'd4
   } state_t;

   // Status exposes only a nibble of FIFO level, pinned at 15 above that.
   function automatic logic [3:0] sat_nibble(input logic [31:0] lvl);
      return (lvl > 32'd15) ? 4'hF : lvl[3:0];
   endfunction

endpackage

// File: rtl/sfr_ws2812_tx_byte_fifo.sv
// Synchronous byte FIFO with push/pop/flush, full/empty flags and fill level.
// Depth need not be a power of two; pointers wrap explicitly.
module sfr_ws2812_tx_byte_fifo #(
   parameter int DEPTH = 48
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           push_i,
   input  logic                           pop_i,
   input  logic                           flush_i,
   input  logic [7:0]                     wdata_i,
   output logic [7:0]                     rdata_o,
   output logic                           full_o,
   output logic                           empty_o,
   output logic [$clog2(DEPTH+1)-1:0]     level_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   logic [7:0]       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [LVL_W-1:0] lvl_q, lvl_d;
   logic             do_push, do_pop;

   assign full_o  = (lvl_q == LVL_W'(DEPTH));
   assign empty_o = (lvl_q == '0);
   assign level_o = lvl_q;
   assign rdata_o = mem_q[rd_q];

   // A push at full is still accepted when a pop frees a slot in the same cycle.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      lvl_d = lvl_q;
      if (flush_i) begin
         wr_d  = '0;
         rd_d  = '0;
         lvl_d = '0;
      end else begin
         if (do_push) wr_d = (wr_q == PTR_LAST) ? '0 : wr_q + 1'b1;
         if (do_pop)  rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   lvl_d = lvl_q + 1'b1;
            2'b01:   lvl_d = lvl_q - 1'b1;
            default: lvl_d = lvl_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         lvl_q <= lvl_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
   end

endmodule

// File: rtl/sfr_ws2812_tx.sv
// SFR-mapped WS2812 frame transmitter: byte FIFO, NRZ bit encoder, latch timer.
// Define WS2812_IRQ_EN to get a one-cycle irq pulse at frame end; otherwise irq=0.
module sfr_ws2812_tx
   import sfr_ws2812_tx_pkg::*;
#(
   parameter logic [7:0] DATA_ADDR  = DEF_DATA_ADDR,
   parameter logic [7:0] CTRL_ADDR  = DEF_CTRL_ADDR,
   parameter int         FIFO_DEPTH = 48,
   parameter int         T0H_CYC    = 20,
   parameter int         T1H_CYC    = 40,
   parameter int         TBIT_CYC   = 63,
   parameter int         TRST_CYC   = 15000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] sfr_addr,
   input  logic [7:0] sfr_data_in,
   output logic [7:0] sfr_data_out,
   input  logic       sfr_wr,
   input  logic       sfr_rd,
   output logic       sfr_sel,
   output logic       din,
   output logic       irq
);

   localparam int CNT_W = $clog2(TRST_CYC + 1);
   localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] T0H_END  = CNT_W'(T0H_CYC - 1);
   localparam logic [CNT_W-1:0] T1H_END  = CNT_W'(T1H_CYC - 1);
   localparam logic [CNT_W-1:0] TBIT_END = CNT_W'(TBIT_CYC - 1);
   localparam logic [CNT_W-1:0] TRST_END = CNT_W'(TRST_CYC - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             din_q, din_d;
   logic             ovf_q, ovf_d;

   logic             sel_data, sel_ctrl, data_wr, ctrl_wr;
   logic             start_cmd, flush_cmd, clr_ovf;
   logic             fifo_pop, fifo_flush, fifo_full, fifo_empty;
   logic [7:0]       fifo_rdata, status;
   logic [LVL_W-1:0] fifo_level;
   logic [CNT_W-1:0] th_end;
   logic             busy;

   assign sel_data  = (sfr_addr == DATA_ADDR);
   assign sel_ctrl  = (sfr_addr == CTRL_ADDR);
   assign sfr_sel   = sel_data | sel_ctrl;
   assign data_wr   = sfr_wr & sel_data;
   assign ctrl_wr   = sfr_wr & sel_ctrl;
   // FLUSH is evaluated first, so a START issued alongside it is dropped.
   assign flush_cmd = ctrl_wr & sfr_data_in[CTRL_FLUSH];
   assign start_cmd = ctrl_wr & sfr_data_in[CTRL_START] & ~sfr_data_in[CTRL_FLUSH];
   assign clr_ovf   = ctrl_wr & sfr_data_in[CTRL_CLR_OVF];

   sfr_ws2812_tx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (data_wr),
      .pop_i   (fifo_pop),
      .flush_i (fifo_flush),
      .wdata_i (sfr_data_in),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign busy   = (state_q != S_IDLE);
   assign status = {sat_nibble(32'(fifo_level)), ovf_q, fifo_empty, fifo_full, busy};
   assign sfr_data_out = (sel_ctrl & sfr_rd) ? status : 8'h00;

   assign ovf_d  = clr_ovf ? 1'b0 : ((data_wr & fifo_full & ~fifo_pop) ? 1'b1 : ovf_q);
   assign th_end = shift_q[7] ? T1H_END : T0H_END;

   // One counter spans the whole bit: HIGH ends at th_end, LOW at TBIT_END.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      fifo_pop   = 1'b0;
      fifo_flush = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_cmd && !fifo_empty) state_d = S_LOAD;
         end
         S_LOAD: begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            bit_d    = 3'd7;
            cnt_d    = '0;
            state_d  = S_HIGH;
         end
         S_HIGH: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == th_end) state_d = S_LOW;
         end
         S_LOW: begin
            if (cnt_q == TBIT_END) begin
               cnt_d = '0;
               if (bit_q != 3'd0) begin
                  bit_d   = bit_q - 1'b1;
                  shift_d = {shift_q[6:0], 1'b0};
                  state_d = S_HIGH;
               end else if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_rdata;
                  bit_d    = 3'd7;
                  state_d  = S_HIGH;
               end else begin
                  state_d = S_LATCH;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_LATCH: begin
            if (cnt_q == TRST_END) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (flush_cmd) begin
         fifo_flush = 1'b1;
         fifo_pop   = 1'b0;
         if (state_q != S_IDLE) begin
            state_d = S_LATCH;
            cnt_d   = '0;
         end
      end
   end

   assign din_d = (state_d == S_HIGH);
   assign din   = din_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         din_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         din_q   <= din_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      shift_q <= shift_d;
   end

`ifdef WS2812_IRQ_EN
   logic irq_q, irq_d;
   assign irq_d = (state_q == S_LATCH) && (state_d == S_IDLE);
   assign irq   = irq_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) irq_q <= 1'b0;
      else     irq_q <= irq_d;
   end
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_sfr_ws2812_tx.sv
// Self-checking bench for sfr_ws2812_tx: pulse widths are scoreboarded per bit,
// status reads and frame timing are checked against fixed expectations.
module tb_sfr_ws2812_tx;

   localparam logic [7:0] DATA_A = 8'hC1;
   localparam logic [7:0] CTRL_A = 8'hC2;
   localparam int TBIT = 63;
   localparam int TRST = 15000;
`ifdef WS2812_IRQ_EN
   localparam int EXP_IRQ = 1;
`else
   localparam int EXP_IRQ = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] sfr_addr = 8'h00;
   logic [7:0] sfr_data_in = 8'h00;
   logic       sfr_wr = 1'b0;
   logic       sfr_rd = 1'b0;
   logic [7:0] sfr_data_out;
   logic       sfr_sel;
   logic       din;
   logic       irq;

   int n_cmp = 0;
   int n_err = 0;
   int exp_q[$];
   bit mon_en = 1'b0;
   int mon_hi = 0;
   int mon_lo = 0;
   int mon_last = 0;
   bit mon_prev = 1'b0;

   sfr_ws2812_tx dut (
      .clk          (clk),
      .rst          (rst),
      .sfr_addr     (sfr_addr),
      .sfr_data_in  (sfr_data_in),
      .sfr_data_out (sfr_data_out),
      .sfr_wr       (sfr_wr),
      .sfr_rd       (sfr_rd),
      .sfr_sel      (sfr_sel),
      .din          (din),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      sfr_addr    = a;
      sfr_data_in = d;
      sfr_wr      = 1'b1;
      @(negedge clk);
      sfr_wr      = 1'b0;
      sfr_addr    = 8'h00;
   endtask

   task automatic rd_status(output logic [7:0] s);
      sfr_addr = CTRL_A;
      sfr_rd   = 1'b1;
      #1;
      s        = sfr_data_out;
      sfr_rd   = 1'b0;
      sfr_addr = 8'h00;
   endtask

   task automatic push_byte(input logic [7:0] d, input bit track);
      sfr_write(DATA_A, d);
      if (track) for (int i = 7; i >= 0; i--) exp_q.push_back(d[i] ? 40 : 20);
   endtask

   task automatic start_frame(input int exp_st);
      logic [7:0] s;
      sfr_write(CTRL_A, 8'h01);
      chk("start_load_din", din, 0);
      rd_status(s);
      chk("start_status", s, exp_st);
      @(negedge clk);
      chk("start_din_rise", din, 1);
   endtask

   task automatic wait_idle(input int hi_from, output int cyc, output int irqs, output int late_hi);
      logic [7:0] s;
      cyc = 0; irqs = 0; late_hi = 0;
      while (cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (irq === 1'b1) irqs++;
         if (cyc >= hi_from && din !== 1'b0) late_hi++;
         rd_status(s);
         if (s[0] == 1'b0) break;
      end
      repeat (3) begin
         @(negedge clk);
         if (irq === 1'b1) irqs++;
      end
   endtask

   // Pulse monitor: pops one expected high width per observed din pulse.
   initial begin
      int e;
      forever begin
         @(negedge clk);
         if (!mon_en || rst) begin
            mon_hi = 0; mon_lo = 0; mon_prev = 1'b0;
         end else if (din === 1'b1) begin
            if (mon_hi == 0 && mon_prev) begin
               chk("bit_period", mon_last + mon_lo, TBIT);
               mon_prev = 1'b0;
            end
            mon_hi++;
         end else begin
            if (mon_hi > 0) begin
               if (exp_q.size() == 0) chk("unexpected_pulse", mon_hi, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("high_width", mon_hi, e);
               end
               mon_last = mon_hi; mon_hi = 0; mon_lo = 0; mon_prev = 1'b1;
            end
            mon_lo++;
            if (mon_lo > 200) mon_prev = 1'b0;
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] s;
      int cyc, irqs, late;

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_din", din, 0);
      chk("reset_irq", irq, 0);
      rd_status(s);
      chk("reset_status", s, 8'h04);
      sfr_addr = CTRL_A; #1;
      chk("sel_ctrl", sfr_sel, 1);
      chk("unread_data_out", sfr_data_out, 8'h00);
      sfr_addr = DATA_A; #1;
      chk("sel_data", sfr_sel, 1);
      sfr_addr = 8'h55; sfr_rd = 1'b1; #1;
      chk("sel_other", sfr_sel, 0);
      chk("other_data_out", sfr_data_out, 8'h00);
      sfr_rd = 1'b0; sfr_addr = 8'h00;

      // Three-byte frame: 0x80, 0x00, 0xFF
      mon_en = 1'b1;
      push_byte(8'h80, 1'b1);
      push_byte(8'h00, 1'b1);
      push_byte(8'hFF, 1'b1);
      rd_status(s);
      chk("three_queued", s, 8'h30);
      start_frame(8'h31);
      wait_idle(24 * TBIT, cyc, irqs, late);
      chk("frame3_len", cyc, 24 * TBIT + TRST);
      chk("frame3_latch_low", late, 0);
      chk("frame3_irq", irqs, EXP_IRQ);
      chk("frame3_drain", exp_q.size(), 0);
      rd_status(s);
      chk("frame3_status", s, 8'h04);

      // Fill to full, overflow, clear overflow, flush while idle
      for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b0);
      rd_status(s);
      chk("level_sat16", s, 8'hF0);
      for (int i = 16; i < 47; i++) push_byte(8'(i), 1'b0);
      rd_status(s);
      chk("level_47", s, 8'hF0);
      push_byte(8'h2F, 1'b0);
      rd_status(s);
      chk("full_48", s, 8'hF2);
      push_byte(8'hEE, 1'b0);
      rd_status(s);
      chk("overflow_49", s, 8'hFA);
      sfr_write(CTRL_A, 8'h04);
      rd_status(s);
      chk("clr_ovf", s, 8'hF2);
      sfr_write(CTRL_A, 8'h03);
      rd_status(s);
      chk("flush_idle_no_start", s, 8'h04);

      // FLUSH abort mid-HIGH
      mon_en = 1'b0;
      push_byte(8'hAA, 1'b0);
      push_byte(8'h55, 1'b0);
      start_frame(8'h21);
      repeat (5) @(negedge clk);
      sfr_write(CTRL_A, 8'h02);
      chk("flush_din", din, 0);
      rd_status(s);
      chk("flush_status", s, 8'h05);
      wait_idle(1, cyc, irqs, late);
      chk("flush_latch_len", cyc, TRST);
      chk("flush_latch_low", late, 0);
      chk("flush_irq", irqs, EXP_IRQ);

      // Asynchronous reset in the middle of a HIGH phase
      push_byte(8'hFF, 1'b0);
      start_frame(8'h11);
      repeat (10) @(negedge clk);
      #3 rst = 1'b1;
      #1 chk("rst_async_din", din, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rd_status(s);
      chk("rst_mid_status", s, 8'h04);
      chk("rst_mid_din", din, 0);

      // One-byte frame, irq at busy fall
      mon_en = 1'b1;
      push_byte(8'h00, 1'b1);
      start_frame(8'h11);
      wait_idle(8 * TBIT, cyc, irqs, late);
      chk("frame1_len", cyc, 8 * TBIT + TRST);
      chk("frame1_latch_low", late, 0);
      chk("frame1_irq", irqs, EXP_IRQ);
      chk("frame1_drain", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
